// File: rtl/choose_select_ctrl.sv
// Two-player character-select sequencer: moves the grid cursor, locks picks, plays the
// acknowledge blink and reports both picks to the scene FSM.
module choose_select_ctrl #(
   parameter int unsigned BLINK_HALF    = 25_000_000,
   parameter int unsigned BLINK_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_confirm,
   input  logic       btn_back,
   output logic [7:0] pokemon_id,
   output logic       frame_on,
   output logic [7:0] p1_id,
   output logic [7:0] p2_id,
   output logic       pick_valid,
   output logic       done,
   output logic [2:0] state_o
);

   localparam int unsigned HalfW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int unsigned TogW  = $clog2(BLINK_TOGGLES + 1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StP1Sel = 3'd1,
      StP1Ack = 3'd2,
      StP2Sel = 3'd3,
      StP2Ack = 3'd4,
      StDone  = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        id_q, id_d;
   logic [7:0]        p1_q, p1_d;
   logic [7:0]        p2_q, p2_d;
   logic              frame_q, frame_d;
   logic              pv_q, pv_d;
   logic              done_q, done_d;
   logic [HalfW-1:0]  half_q, half_d;
   logic [TogW-1:0]   tog_q, tog_d;
   logic [6:0]        prev_q, prev_d;

   logic [6:0] btn_all;
   logic [6:0] edge_v;
   logic       e_start;
   logic       win_conf, win_back, win_left, win_right, win_up, win_down, win_move;
   logic [7:0] id_moved;

   assign btn_all = {start, btn_confirm, btn_back, btn_left, btn_right, btn_up, btn_down};
   assign edge_v  = btn_all & ~prev_q;
   assign e_start = edge_v[6];

   // Only the highest-priority button edge acts; the rest are dropped.
   assign win_conf  = edge_v[5];
   assign win_back  = edge_v[4] & ~edge_v[5];
   assign win_left  = edge_v[3] & ~|edge_v[5:4];
   assign win_right = edge_v[2] & ~|edge_v[5:3];
   assign win_up    = edge_v[1] & ~|edge_v[5:2];
   assign win_down  = edge_v[0] & ~|edge_v[5:1];
   assign win_move  = win_left | win_right | win_up | win_down;

   // Ids 1..8 map onto {row, col} of (id-1); id 8 has low bits 000 which also wraps correctly.
   function automatic logic [7:0] move_id(input logic [2:0] id_lo, input logic l, input logic r,
                                          input logic ud);
      logic [2:0] idx;
      logic [1:0] col;
      logic       row;
      idx = id_lo - 3'd1;
      col = idx[1:0];
      row = idx[2];
      if (l) begin
         col = col - 2'd1;
      end else if (r) begin
         col = col + 2'd1;
      end else if (ud) begin
         row = ~row;
      end
      return {5'd0, row, col} + 8'd1;
   endfunction

   assign id_moved = move_id(id_q[2:0], win_left, win_right, win_up | win_down);

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      frame_d = frame_q;
      pv_d    = 1'b0;
      done_d  = done_q;
      half_d  = half_q;
      tog_d   = tog_q;
      prev_d  = btn_all;

      unique case (state_q)
         StIdle: begin
            frame_d = 1'b0;
            if (e_start) begin
               state_d = StP1Sel;
               id_d    = 8'd1;
               frame_d = 1'b1;
            end
         end
         StP1Sel: begin
            if (win_conf) begin
               p1_d    = id_q;
               pv_d    = 1'b1;
               half_d  = '0;
               tog_d   = '0;
               state_d = StP1Ack;
            end else if (win_move) begin
               id_d = id_moved;
            end
         end
         StP1Ack, StP2Ack: begin
            if (half_q == HalfW'(BLINK_HALF - 1)) begin
               half_d  = '0;
               frame_d = ~frame_q;
               tog_d   = tog_q + TogW'(1);
               if (tog_q == TogW'(BLINK_TOGGLES - 1)) begin
                  tog_d = '0;
                  if (state_q == StP1Ack) begin
                     state_d = StP2Sel;
                     id_d    = (p1_q == 8'd8) ? 8'd1 : p1_q + 8'd1;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     id_d    = p2_q;
                     frame_d = 1'b1;
                  end
               end
            end else begin
               half_d = half_q + HalfW'(1);
            end
         end
         StP2Sel: begin
            if (win_conf) begin
               if (id_q != p1_q) begin
                  p2_d    = id_q;
                  pv_d    = 1'b1;
                  half_d  = '0;
                  tog_d   = '0;
                  state_d = StP2Ack;
               end
            end else if (win_back) begin
               p1_d    = 8'd0;
               id_d    = p1_q;
               state_d = StP1Sel;
            end else if (win_move) begin
               id_d = id_moved;
            end
         end
         StDone: begin
            frame_d = 1'b1;
            done_d  = 1'b1;
            if (e_start) begin
               p1_d    = 8'd0;
               p2_d    = 8'd0;
               done_d  = 1'b0;
               id_d    = 8'd1;
               state_d = StP1Sel;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         id_q    <= 8'd1;
         p1_q    <= 8'd0;
         p2_q    <= 8'd0;
         frame_q <= 1'b0;
         pv_q    <= 1'b0;
         done_q  <= 1'b0;
         half_q  <= '0;
         tog_q   <= '0;
         prev_q  <= '1;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         frame_q <= frame_d;
         pv_q    <= pv_d;
         done_q  <= done_d;
         half_q  <= half_d;
         tog_q   <= tog_d;
         prev_q  <= prev_d;
      end
   end

   assign pokemon_id = id_q;
   assign frame_on   = frame_q;
   assign p1_id      = p1_q;
   assign p2_id      = p2_q;
   assign pick_valid = pv_q;
   assign done       = done_q;
   assign state_o    = state_q;

endmodule
